// File: rtl/mat_fifo_pkg.sv
// Shared defaults and flag bundle for the matrix-datapath sync FIFO.
// Imported by the FIFO top and its RAM.
package mat_fifo_pkg;

    localparam int unsigned MAT_ADDR_WIDTH = 10;
    localparam int unsigned MAT_DATA_WIDTH = 8;
    localparam int unsigned MAT_AF_NUM     = 11;
    localparam int unsigned MAT_AE_NUM     = 4;
    localparam int unsigned MAT_DEPTH      = 2 ** MAT_ADDR_WIDTH;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } mat_flags_t;

    localparam mat_flags_t MAT_FLAGS_RST = '{
        full:         1'b0,
        almost_full:  1'b0,
        empty:        1'b1,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/mat_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// Array carries no reset; only the read register is cleared.
module mat_fifo_ram
    import mat_fifo_pkg::*;
#(
    parameter int unsigned AW = MAT_ADDR_WIDTH,
    parameter int unsigned DW = MAT_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    // Store the write word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read word: load on accepted read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[raddr];
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/mat_sync_fifo.sv
// Single-clock FIFO for the pixel/matrix datapath with full/empty and
// programmable almost flags, all registered from the next-cycle count.
module mat_sync_fifo
    import mat_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = MAT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH       = MAT_DATA_WIDTH,
    parameter int unsigned ALMOST_FULL_NUM  = MAT_AF_NUM,
    parameter int unsigned ALMOST_EMPTY_NUM = MAT_AE_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(2 ** ADDR_WIDTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_NUM);
    localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_NUM);

    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]         cnt_d, cnt_q;
    mat_flags_t            flags_d, flags_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Gate requests against the current flags.
    always_comb begin
        wr_ok = wr_en && !flags_q.full;
        rd_ok = rd_en && !flags_q.empty;
    end

    // Next pointers, occupancy and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        flags_d.full         = (cnt_d == FULL_CNT);
        flags_d.almost_full  = (cnt_d >= AF_CNT);
        flags_d.empty        = (cnt_d == '0);
        flags_d.almost_empty = (cnt_d <= AE_CNT);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            flags_q  <= MAT_FLAGS_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
        end
    end

    mat_fifo_ram #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign full         = flags_q.full;
    assign almost_full  = flags_q.almost_full;
    assign empty        = flags_q.empty;
    assign almost_empty = flags_q.almost_empty;

endmodule

// File: tb/tb_mat_sync_fifo.sv
// Directed bench for mat_sync_fifo: reset, fill, drain, simultaneous
// access at the boundaries and asynchronous reset mid-stream.
module tb_mat_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       almost_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       almost_empty;

    int checks;
    int failures;

    mat_sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic flags(input string tag, input logic f, input logic af,
                         input logic e, input logic ae);
        check({tag, ".full"}, 32'(full), 32'(f));
        check({tag, ".af"}, 32'(almost_full), 32'(af));
        check({tag, ".empty"}, 32'(empty), 32'(e));
        check({tag, ".ae"}, 32'(almost_empty), 32'(ae));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;

        #200;
        flags("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst.rd_data", 32'(rd_data), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 0) check("fill.empty1", 32'(empty), 32'd0);
            if (i == 3) check("fill.ae4", 32'(almost_empty), 32'd1);
            if (i == 4) check("fill.ae5", 32'(almost_empty), 32'd0);
            if (i == 9) check("fill.af10", 32'(almost_full), 32'd0);
            if (i == 10) check("fill.af11", 32'(almost_full), 32'd1);
            if (i == 1022) check("fill.full1023", 32'(full), 32'd0);
        end
        flags("fill.done", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0);
        check("fill.extra_full", 32'(full), 32'd1);
        check("fill.extra_rd", 32'(rd_data), 32'h0);

        for (int i = 0; i < 1024; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("drain.data", 32'(rd_data), 32'(i % 256));
            if (i == 0) check("drain.full", 32'(full), 32'd0);
            if (i == 1012) check("drain.af11", 32'(almost_full), 32'd1);
            if (i == 1013) check("drain.af10", 32'(almost_full), 32'd0);
            if (i == 1018) check("drain.ae5", 32'(almost_empty), 32'd0);
            if (i == 1019) check("drain.ae4", 32'(almost_empty), 32'd1);
            if (i == 1022) check("drain.empty1", 32'(empty), 32'd0);
        end
        flags("drain.done", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check("drain.extra_rd", 32'(rd_data), 32'd255);
        check("drain.extra_empty", 32'(empty), 32'd1);

        cyc(1'b1, 8'h5A, 1'b1);
        check("se.rd_hold", 32'(rd_data), 32'd255);
        flags("se", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check("se.rd", 32'(rd_data), 32'h5A);
        check("se.empty", 32'(empty), 32'd1);

        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 8'(i) ^ 8'h3C, 1'b0);
        end
        check("sf.full_before", 32'(full), 32'd1);
        cyc(1'b1, 8'hEE, 1'b1);
        check("sf.rd", 32'(rd_data), 32'h3C);
        flags("sf", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        check("sf.refull", 32'(full), 32'd1);
        for (int i = 1; i < 1024; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("sf.drain", 32'(rd_data), 32'(8'(i) ^ 8'h3C));
        end
        cyc(1'b0, 8'h00, 1'b1);
        check("sf.last", 32'(rd_data), 32'h77);
        check("sf.empty", 32'(empty), 32'd1);

        for (int i = 0; i < 500; i++) begin
            cyc(1'b1, 8'(i + 7), 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h11, 1'b0);
        check("ar.rd_pre", 32'(rd_data), 32'h7);
        flags("ar.pre", 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        flags("ar.now", 1'b0, 1'b0, 1'b1, 1'b1);
        check("ar.rd_now", 32'(rd_data), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 8'hC3, 1'b0);
        check("ar.empty_w", 32'(empty), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        check("ar.rd", 32'(rd_data), 32'hC3);
        check("ar.empty_r", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
